adder_rr_scheduler: RTL and testbench

//  Shares one clocked WIDTH-bit adder (the ripple carry adder with clk/sum/cout/overflow) among NUM_REQ requesters.

---
 rtl/adder_rr_scheduler_pkg.sv | 19 +
 rtl/adder_rr_scheduler_if.sv | 40 ++++
 rtl/adder_rr_scheduler_arbiter.sv | 35 +++
 rtl/adder_rr_scheduler.sv | 108 ++++++++++
 tb/tb_adder_rr_scheduler.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/adder_rr_scheduler_pkg.sv
// rtl/adder_rr_scheduler_pkg.sv - shared types and width helpers for the adder scheduler
package adder_rr_scheduler_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    function automatic int id_width(input int num_req);
        return (num_req <= 2) ? 1 : $clog2(num_req);
    endfunction

    // Counter must be able to hold ADD_LAT itself
    function automatic int lat_width(input int add_lat);
        return (add_lat < 1) ? 1 : $clog2(add_lat + 1);
    endfunction

endpackage

// File: rtl/adder_rr_scheduler_if.sv
// rtl/adder_rr_scheduler_if.sv - request, shared-adder and response signals of the scheduler
interface adder_rr_scheduler_if #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 32
);
    import adder_rr_scheduler_pkg::*;
    localparam int ID_W = id_width(NUM_REQ);

    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ*WIDTH-1:0] req_a;
    logic [NUM_REQ*WIDTH-1:0] req_b;
    logic [NUM_REQ-1:0]       req_cin;
    logic [WIDTH-1:0]         add_a;
    logic [WIDTH-1:0]         add_b;
    logic                     add_cin;
    logic [WIDTH-1:0]         add_sum;
    logic                     add_cout;
    logic                     add_overflow;
    logic                     rsp_valid;
    logic                     rsp_ready;
    logic [ID_W-1:0]          rsp_id;
    logic [WIDTH-1:0]         rsp_sum;
    logic                     rsp_cout;
    logic                     rsp_overflow;
    logic                     busy;

    modport slave (
        input  req_valid, req_a, req_b, req_cin, add_sum, add_cout, add_overflow, rsp_ready,
        output req_ready, add_a, add_b, add_cin, rsp_valid, rsp_id, rsp_sum, rsp_cout,
               rsp_overflow, busy
    );

    modport master (
        output req_valid, req_a, req_b, req_cin, add_sum, add_cout, add_overflow, rsp_ready,
        input  req_ready, add_a, add_b, add_cin, rsp_valid, rsp_id, rsp_sum, rsp_cout,
               rsp_overflow, busy
    );

endinterface

// File: rtl/adder_rr_scheduler_arbiter.sv
// rtl/adder_rr_scheduler_arbiter.sv - combinational round-robin arbiter starting at i_ptr
module rr_arbiter
    import adder_rr_scheduler_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int ID_W    = id_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [ID_W-1:0]    i_ptr,
    input  logic               i_en,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [ID_W-1:0]    o_idx,
    output logic               o_any
);

    logic [ID_W-1:0] w_cand;

    // Scan farthest-first so the candidate closest to i_ptr is written last and wins
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        w_cand  = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_cand = ID_W'((int'(i_ptr) + k) % NUM_REQ);
            if (i_en && i_req[w_cand]) begin
                o_grant         = '0;
                o_grant[w_cand] = 1'b1;
                o_idx           = w_cand;
                o_any           = 1'b1;
            end
        end
    end

endmodule

// File: rtl/adder_rr_scheduler.sv
// rtl/adder_rr_scheduler.sv - round-robin sharing of one clocked adder among NUM_REQ requesters
module adder_rr_scheduler
    import adder_rr_scheduler_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 32,
    parameter int ADD_LAT = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    adder_rr_scheduler_if.slave bus
);

    localparam int ID_W  = id_width(NUM_REQ);
    localparam int LAT_W = lat_width(ADD_LAT);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [ID_W-1:0]    r_ptr;
    logic [ID_W-1:0]    r_id;
    logic [LAT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic               r_cin;
    logic [WIDTH-1:0]   r_sum;
    logic               r_cout;
    logic               r_ovf;
    logic               r_rsp_valid;
    logic [NUM_REQ-1:0] w_grant;
    logic [ID_W-1:0]    w_idx;
    logic               w_accept;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .i_req   (bus.req_valid),
        .i_ptr   (r_ptr),
        .i_en    (r_state == IDLE),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_any   (w_accept)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept)       w_state_nxt = WAIT;
            WAIT:    if (r_cnt == '0)    w_state_nxt = RESP;
            RESP:    if (bus.rsp_ready)  w_state_nxt = IDLE;
            default:                     w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_ptr       <= '0;
            r_id        <= '0;
            r_cnt       <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_cin       <= 1'b0;
            r_sum       <= '0;
            r_cout      <= 1'b0;
            r_ovf       <= 1'b0;
            r_rsp_valid <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_a   <= bus.req_a[w_idx*WIDTH +: WIDTH];
                        r_b   <= bus.req_b[w_idx*WIDTH +: WIDTH];
                        r_cin <= bus.req_cin[w_idx];
                        r_id  <= w_idx;
                        r_ptr <= (w_idx == ID_W'(NUM_REQ - 1)) ? '0 : w_idx + 1'b1;
                        // The adder only samples add_* on the edge after accept, hence ADD_LAT not ADD_LAT-1
                        r_cnt <= LAT_W'(ADD_LAT);
                    end
                end
                WAIT: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else begin
                        r_sum       <= bus.add_sum;
                        r_cout      <= bus.add_cout;
                        r_ovf       <= bus.add_overflow;
                        r_rsp_valid <= 1'b1;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) r_rsp_valid <= 1'b0;
                end
                default: r_rsp_valid <= 1'b0;
            endcase
        end
    end

    assign bus.req_ready    = w_grant;
    assign bus.add_a        = r_a;
    assign bus.add_b        = r_b;
    assign bus.add_cin      = r_cin;
    assign bus.rsp_valid    = r_rsp_valid;
    assign bus.rsp_id       = r_id;
    assign bus.rsp_sum      = r_sum;
    assign bus.rsp_cout     = r_cout;
    assign bus.rsp_overflow = r_ovf;
    assign bus.busy         = (r_state != IDLE);

endmodule

// File: tb/tb_adder_rr_scheduler.sv
// tb/tb_adder_rr_scheduler.sv - directed bench for adder_rr_scheduler with a registered adder model
module tb_adder_rr_scheduler;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    adder_rr_scheduler_if #(.NUM_REQ(4), .WIDTH(32)) bus ();

    adder_rr_scheduler #(.NUM_REQ(4), .WIDTH(32), .ADD_LAT(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shared ripple adder with one register stage
    logic [32:0] w_full;
    always_comb w_full = {1'b0, bus.add_a} + {1'b0, bus.add_b} + {32'b0, bus.add_cin};
    always_ff @(posedge clk) begin
        bus.add_sum      <= w_full[31:0];
        bus.add_cout     <= w_full[32];
        bus.add_overflow <= (bus.add_a[31] == bus.add_b[31]) && (w_full[31] != bus.add_a[31]);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Called at a negedge with the DUT idle; runs one op and completes the handshake
    task automatic do_op(input string tag, input int id, input logic [31:0] a, input logic [31:0] b,
                         input logic cin, input logic [31:0] es, input logic ec, input logic eo,
                         input int stall);
        int   waited;
        logic got;
        bus.req_a[id*32 +: 32] = a;
        bus.req_b[id*32 +: 32] = b;
        bus.req_cin[id]        = cin;
        bus.req_valid[id]      = 1'b1;
        got    = 1'b0;
        waited = 0;
        while (!got && waited < 8) begin
            #1;
            if (bus.req_ready[id]) got = 1'b1;
            else begin
                @(negedge clk);
                waited++;
            end
        end
        check({tag, " grant"}, 64'(got), 64'(1));
        if (!got) begin
            bus.req_valid[id] = 1'b0;
            return;
        end
        @(negedge clk);
        bus.req_valid[id] = 1'b0;
        check({tag, " valid_c1"}, 64'(bus.rsp_valid), 64'(0));
        check({tag, " busy_c1"}, 64'(bus.busy), 64'(1));
        @(negedge clk);
        check({tag, " valid_c2"}, 64'(bus.rsp_valid), 64'(0));
        @(negedge clk);
        check({tag, " valid_c3"}, 64'(bus.rsp_valid), 64'(1));
        check({tag, " id"}, 64'(bus.rsp_id), 64'(id));
        check({tag, " sum"}, 64'(bus.rsp_sum), 64'(es));
        check({tag, " cout"}, 64'(bus.rsp_cout), 64'(ec));
        check({tag, " ovf"}, 64'(bus.rsp_overflow), 64'(eo));
        if (stall > 0) bus.req_valid[(id + 1) % 4] = 1'b1;
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            check({tag, " stall_valid"}, 64'(bus.rsp_valid), 64'(1));
            check({tag, " stall_sum"}, 64'(bus.rsp_sum), 64'(es));
            check({tag, " stall_id"}, 64'(bus.rsp_id), 64'(id));
            check({tag, " stall_ready"}, 64'(bus.req_ready), 64'(0));
            check({tag, " stall_busy"}, 64'(bus.busy), 64'(1));
        end
        bus.req_valid[(id + 1) % 4] = 1'b0;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        check({tag, " done_valid"}, 64'(bus.rsp_valid), 64'(0));
        check({tag, " done_busy"}, 64'(bus.busy), 64'(0));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp         = 0;
        n_err         = 0;
        rst_n         = 1'b0;
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_cin   = '0;
        bus.rsp_ready = 1'b0;
        do_reset();
        #1;
        check("rst req_ready", 64'(bus.req_ready), 64'(0));
        check("rst rsp_valid", 64'(bus.rsp_valid), 64'(0));
        check("rst busy", 64'(bus.busy), 64'(0));
        check("rst add_a", 64'(bus.add_a), 64'(0));
        check("rst add_cin", 64'(bus.add_cin), 64'(0));

        do_op("t1 max+1", 0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 0);
        do_op("t2 min-1", 2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1, 0);
        do_op("t2 100-50", 1, 32'd100, 32'hFFFF_FFCE, 1'b0, 32'd50, 1'b1, 1'b0, 0);

        // Rotation with all four valid; rr_ptr starts at 0 after reset
        do_reset();
        for (int i = 0; i < 4; i++) begin
            bus.req_a[i*32 +: 32] = 32'(i * 1000);
            bus.req_b[i*32 +: 32] = 32'(i);
            bus.req_cin[i]        = 1'b0;
        end
        bus.req_valid = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            #1;
            check("t3 grant", 64'(bus.req_ready), 64'(4'b0001 << (n % 4)));
            @(negedge clk);
            @(negedge clk);
            @(negedge clk);
            check("t3 valid", 64'(bus.rsp_valid), 64'(1));
            check("t3 id", 64'(bus.rsp_id), 64'(n % 4));
            check("t3 sum", 64'(bus.rsp_sum), 64'((n % 4) * 1001));
            bus.rsp_ready = 1'b1;
            @(negedge clk);
            bus.rsp_ready = 1'b0;
        end
        bus.req_valid = '0;
        bus.req_cin   = '0;

        do_op("t4 stall", 2, 32'd7, 32'd8, 1'b1, 32'd16, 1'b0, 1'b0, 5);

        // Reset with req3 in flight
        do_reset();
        bus.req_a[3*32 +: 32] = 32'd5;
        bus.req_b[3*32 +: 32] = 32'd6;
        bus.req_valid[3]      = 1'b1;
        #1;
        check("t5 grant3", 64'(bus.req_ready), 64'(4'b1000));
        @(negedge clk);
        bus.req_valid[3] = 1'b0;
        check("t5 busy_wait", 64'(bus.busy), 64'(1));
        rst_n = 1'b0;
        #1;
        check("t5 busy_rst", 64'(bus.busy), 64'(0));
        check("t5 add_a_rst", 64'(bus.add_a), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("t5 no_rsp", 64'(bus.rsp_valid), 64'(0));
        end
        bus.req_valid = 4'b1010;
        #1;
        check("t5 grant1_first", 64'(bus.req_ready), 64'(4'b0010));
        bus.req_valid[3] = 1'b0;
        @(negedge clk);
        bus.req_valid[1] = 1'b0;
        check("t5 busy_op", 64'(bus.busy), 64'(1));
        @(negedge clk);
        @(negedge clk);
        check("t5 rsp_id", 64'(bus.rsp_id), 64'(1));
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;

        do_op("t6 neg", 1, 32'hFFFE_7960, 32'd99999, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0, 0);
        do_op("t6 cin", 1, 32'd0, 32'd0, 1'b1, 32'd1, 1'b0, 1'b0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
